// File: rtl/reveal_cells.sv
// reveal_cells: flood-fill reveal controller for the minesweeper boards.
// A click reveals one cell; a click on a zero-adjacency cell opens the whole
// connected zero region plus its border using an explicit work stack.
module reveal_cells #(
    parameter int boardWidth  = 8,
    parameter int boardHeight = 8
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic                                        start,
    input  logic                                        ack,
    input  logic [$clog2(boardWidth)-1:0]               clickX,
    input  logic [$clog2(boardHeight)-1:0]              clickY,
    output logic [$clog2(boardWidth)-1:0]               boardX,
    output logic [$clog2(boardHeight)-1:0]              boardY,
    input  logic                                        mineReadValue,
    input  logic [3:0]                                  adjReadValue,
    input  logic                                        revealedReadValue,
    output logic                                        revealEn,
    output logic                                        hitMine,
    output logic [$clog2(boardWidth*boardHeight+1)-1:0] revealedCount,
    output logic                                        init,
    output logic                                        check,
    output logic                                        pop,
    output logic                                        neigh,
    output logic                                        done
);

    localparam int XW    = $clog2(boardWidth);
    localparam int YW    = $clog2(boardHeight);
    localparam int CELLS = boardWidth * boardHeight;
    localparam int CW    = $clog2(CELLS + 1);
    localparam int SW    = $clog2(CELLS);

    localparam logic [XW-1:0] X_MAX = XW'(boardWidth - 1);
    localparam logic [YW-1:0] Y_MAX = YW'(boardHeight - 1);

    localparam logic [2:0] ST_INIT  = 3'd0;
    localparam logic [2:0] ST_CHECK = 3'd1;
    localparam logic [2:0] ST_POP   = 3'd2;
    localparam logic [2:0] ST_NEIGH = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    logic [2:0]    state;
    logic [XW-1:0] curX;
    logic [YW-1:0] curY;
    logic [2:0]    nIdx;
    logic [CW-1:0] sp;
    logic [CW-1:0] spDec;
    logic [SW-1:0] pushIdx;
    logic [SW-1:0] topIdx;

    // Work stack of zero cells still to be expanded; sized to a power of two
    // so the pointer slice always indexes a legal entry.
    logic [XW-1:0] stackX [2**SW];
    logic [YW-1:0] stackY [2**SW];

    logic          dxNeg, dxPos, dyNeg, dyPos;
    logic          inBounds;
    logic [XW-1:0] nbX;
    logic [YW-1:0] nbY;
    logic          pushEn;

    assign spDec   = sp - CW'(1);
    assign pushIdx = sp[SW-1:0];
    assign topIdx  = spDec[SW-1:0];

    // Decode neighbour index into a direction, scanning row above, same row, row below.
    always_comb begin
        dxNeg = 1'b0;
        dxPos = 1'b0;
        dyNeg = 1'b0;
        dyPos = 1'b0;
        case (nIdx)
            3'd0:    begin dxNeg = 1'b1; dyNeg = 1'b1; end
            3'd1:    dyNeg = 1'b1;
            3'd2:    begin dxPos = 1'b1; dyNeg = 1'b1; end
            3'd3:    dxNeg = 1'b1;
            3'd4:    dxPos = 1'b1;
            3'd5:    begin dxNeg = 1'b1; dyPos = 1'b1; end
            3'd6:    dyPos = 1'b1;
            default: begin dxPos = 1'b1; dyPos = 1'b1; end
        endcase
    end

    // Neighbour coordinates and edge check; no wrap-around at board edges.
    always_comb begin
        inBounds = !(dxNeg && (curX == '0)) && !(dxPos && (curX == X_MAX)) &&
                   !(dyNeg && (curY == '0)) && !(dyPos && (curY == Y_MAX));
        nbX = curX;
        nbY = curY;
        if (dxNeg) nbX = curX - XW'(1);
        if (dxPos) nbX = curX + XW'(1);
        if (dyNeg) nbY = curY - YW'(1);
        if (dyPos) nbY = curY + YW'(1);
    end

    // Board address, reveal strobe and push decision for the current cycle.
    always_comb begin
        boardX   = curX;
        boardY   = curY;
        revealEn = 1'b0;
        if (state == ST_CHECK) begin
            revealEn = !revealedReadValue;
        end else if (state == ST_NEIGH && inBounds) begin
            boardX   = nbX;
            boardY   = nbY;
            revealEn = !revealedReadValue;
        end
        pushEn = revealEn && !mineReadValue && (adjReadValue == 4'd0);
    end

    // Controller state, cursor, stack pointer and result registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= ST_INIT;
            curX          <= '0;
            curY          <= '0;
            nIdx          <= '0;
            sp            <= '0;
            revealedCount <= '0;
            hitMine       <= 1'b0;
        end else begin
            case (state)
                ST_INIT: begin
                    sp <= '0;
                    if (start) begin
                        curX          <= clickX;
                        curY          <= clickY;
                        revealedCount <= '0;
                        hitMine       <= 1'b0;
                        state         <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (revealedReadValue) begin
                        state <= ST_DONE;
                    end else if (mineReadValue) begin
                        hitMine       <= 1'b1;
                        revealedCount <= revealedCount + CW'(1);
                        state         <= ST_DONE;
                    end else begin
                        revealedCount <= revealedCount + CW'(1);
                        if (pushEn) sp <= sp + CW'(1);
                        state <= ST_POP;
                    end
                end
                ST_POP: begin
                    if (sp == '0) begin
                        state <= ST_DONE;
                    end else begin
                        curX  <= stackX[topIdx];
                        curY  <= stackY[topIdx];
                        sp    <= spDec;
                        nIdx  <= '0;
                        state <= ST_NEIGH;
                    end
                end
                ST_NEIGH: begin
                    if (revealEn) revealedCount <= revealedCount + CW'(1);
                    if (pushEn) sp <= sp + CW'(1);
                    nIdx <= nIdx + 3'd1;
                    if (nIdx == 3'd7) state <= ST_POP;
                end
                ST_DONE: begin
                    if (ack) state <= ST_INIT;
                end
                default: state <= ST_INIT;
            endcase
        end
    end

    // Stack storage: a pushed cell is the one currently addressed on the board bus.
    always_ff @(posedge clk) begin
        if (pushEn) begin
            stackX[pushIdx] <= boardX;
            stackY[pushIdx] <= boardY;
        end
    end

    assign init  = (state == ST_INIT);
    assign check = (state == ST_CHECK);
    assign pop   = (state == ST_POP);
    assign neigh = (state == ST_NEIGH);
    assign done  = (state == ST_DONE);

endmodule

// File: tb/tb_reveal_cells.sv
// tb_reveal_cells: self-checking bench for reveal_cells with board models
// and a breadth-first flood-fill reference model.
`timescale 1ns/1ps
module tb_reveal_cells;

    localparam int W = 8;
    localparam int H = 8;
    localparam int N = W * H;

    logic       clk_tb   = 1'b0;
    logic       reset_tb = 1'b0;
    logic       start    = 1'b0;
    logic       ack      = 1'b0;
    logic [2:0] clickX   = '0;
    logic [2:0] clickY   = '0;
    logic [2:0] boardX, boardY;
    logic       mineRd, revRd;
    logic [3:0] adjRd;
    logic       revealEn, hitMine;
    logic [6:0] revealedCount;
    logic       fInit, fCheck, fPop, fNeigh, fDone;

    int checks   = 0;
    int failures = 0;

    bit       mineMem  [N];
    logic [3:0] adjMem [N];
    bit       revMem   [N];
    bit       preRev   [N];
    int       writeCnt [N];
    int       oobCnt;
    bit       loadReq = 1'b0;
    int       rdIdx;

    bit expRev [N];
    int expCount, expHit, expK, expLat;
    int lat;

    reveal_cells #(.boardWidth(W), .boardHeight(H)) dut (
        .clk(clk_tb), .reset(reset_tb), .start(start), .ack(ack),
        .clickX(clickX), .clickY(clickY), .boardX(boardX), .boardY(boardY),
        .mineReadValue(mineRd), .adjReadValue(adjRd), .revealedReadValue(revRd),
        .revealEn(revealEn), .hitMine(hitMine), .revealedCount(revealedCount),
        .init(fInit), .check(fCheck), .pop(fPop), .neigh(fNeigh), .done(fDone)
    );

    always #5 clk_tb = ~clk_tb;

    // Combinational board reads
    always_comb begin
        rdIdx  = int'(boardY) * W + int'(boardX);
        mineRd = 1'b0;
        adjRd  = 4'd0;
        revRd  = 1'b0;
        if (rdIdx < N) begin
            mineRd = mineMem[rdIdx];
            adjRd  = adjMem[rdIdx];
            revRd  = revMem[rdIdx];
        end
    end

    // Revealed board write port plus write log
    always @(posedge clk_tb) begin
        if (loadReq) begin
            for (int i = 0; i < N; i++) begin
                revMem[i]   <= preRev[i];
                writeCnt[i] <= 0;
            end
            oobCnt <= 0;
        end else if (revealEn) begin
            if (int'(boardX) >= W || int'(boardY) >= H) oobCnt <= oobCnt + 1;
            else begin
                revMem[rdIdx]   <= 1'b1;
                writeCnt[rdIdx] <= writeCnt[rdIdx] + 1;
            end
        end
    end

    task automatic clear_board();
        for (int i = 0; i < N; i++) begin
            mineMem[i] = 1'b0;
            preRev[i]  = 1'b0;
        end
    endtask

    task automatic compute_adj();
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) begin
                int c = 0;
                for (int dy = -1; dy <= 1; dy++)
                    for (int dx = -1; dx <= 1; dx++)
                        if (!(dx == 0 && dy == 0) && x + dx >= 0 && x + dx < W &&
                            y + dy >= 0 && y + dy < H && mineMem[(y + dy) * W + x + dx])
                            c++;
                adjMem[y * W + x] = 4'(c);
            end
    endtask

    task automatic load_rev();
        @(negedge clk_tb);
        loadReq = 1'b1;
        @(negedge clk_tb);
        loadReq = 1'b0;
    endtask

    // Reference: breadth-first flood over the zero region from the click
    task automatic model_click(input int cx, input int cy);
        int q[$];
        int c;
        c = cy * W + cx;
        for (int i = 0; i < N; i++) expRev[i] = preRev[i];
        expCount = 0; expHit = 0; expK = 0;
        if (preRev[c]) begin
            expLat = 2;
        end else if (mineMem[c]) begin
            expRev[c] = 1'b1; expCount = 1; expHit = 1; expLat = 2;
        end else begin
            expRev[c] = 1'b1; expCount = 1;
            if (adjMem[c] == 4'd0) q.push_back(c);
            while (q.size() > 0) begin
                int p, px, py;
                p = q.pop_front();
                expK++;
                px = p % W; py = p / W;
                for (int dy = -1; dy <= 1; dy++)
                    for (int dx = -1; dx <= 1; dx++) begin
                        int nx, ny, ni;
                        nx = px + dx; ny = py + dy;
                        if (!(dx == 0 && dy == 0) && nx >= 0 && nx < W && ny >= 0 && ny < H) begin
                            ni = ny * W + nx;
                            if (!expRev[ni]) begin
                                expRev[ni] = 1'b1;
                                expCount++;
                                if (adjMem[ni] == 4'd0) q.push_back(ni);
                            end
                        end
                    end
            end
            expLat = 3 + 9 * expK;
        end
    endtask

    // Cells whose write count or final revealed state disagrees with the model
    function automatic int write_errors();
        int e = 0;
        for (int i = 0; i < N; i++) begin
            if (writeCnt[i] != ((expRev[i] && !preRev[i]) ? 1 : 0)) e++;
            if (revMem[i] != expRev[i]) e++;
        end
        return e;
    endfunction

    task automatic run_click(input int cx, input int cy);
        @(negedge clk_tb);
        clickX = 3'(cx);
        clickY = 3'(cy);
        start  = 1'b1;
        @(negedge clk_tb);
        start = 1'b0;
        lat = 1;
        while (!fDone && lat < 3000) begin
            @(negedge clk_tb);
            lat++;
        end
    endtask

    task automatic do_ack();
        @(negedge clk_tb);
        ack = 1'b1;
        @(negedge clk_tb);
        ack = 1'b0;
    endtask

    task automatic test_reset();
        reset_tb = 1'b0;
        repeat (2) @(negedge clk_tb);
        checks++;
        if ({fInit, fCheck, fPop, fNeigh, fDone} !== 5'b10000) begin
            failures++; $display("FAIL reset_flags: got %b want 10000", {fInit, fCheck, fPop, fNeigh, fDone});
        end
        checks++;
        if ({boardX, boardY} !== 6'd0) begin
            failures++; $display("FAIL reset_addr: got %0d,%0d want 0,0", boardX, boardY);
        end
        checks++;
        if ({revealEn, hitMine} !== 2'b00) begin
            failures++; $display("FAIL reset_outs: got revealEn=%b hitMine=%b want 0 0", revealEn, hitMine);
        end
        checks++;
        if (revealedCount !== 7'd0) begin
            failures++; $display("FAIL reset_count: got %0d want 0", revealedCount);
        end
        reset_tb = 1'b1;
    endtask

    task automatic test_mine_click();
        clear_board();
        mineMem[4 * W + 3] = 1'b1;
        compute_adj();
        load_rev();
        model_click(3, 4);
        run_click(3, 4);
        checks++;
        if (lat !== expLat) begin failures++; $display("FAIL mine_latency: got %0d want %0d", lat, expLat); end
        checks++;
        if (hitMine !== 1'(expHit)) begin failures++; $display("FAIL mine_hit: got %b want %0d", hitMine, expHit); end
        checks++;
        if (int'(revealedCount) !== expCount) begin failures++; $display("FAIL mine_count: got %0d want %0d", revealedCount, expCount); end
        checks++;
        if (writeCnt[4 * W + 3] !== 1 || write_errors() !== 0) begin
            failures++; $display("FAIL mine_writes: got cell=%0d errs=%0d want 1 0", writeCnt[4 * W + 3], write_errors());
        end
        do_ack();
    endtask

    task automatic test_nonzero_click();
        clear_board();
        mineMem[0] = 1'b1;
        compute_adj();
        load_rev();
        model_click(1, 1);
        run_click(1, 1);
        checks++;
        if (lat !== expLat) begin failures++; $display("FAIL nonzero_latency: got %0d want %0d", lat, expLat); end
        checks++;
        if (hitMine !== 1'b0) begin failures++; $display("FAIL nonzero_hit: got %b want 0", hitMine); end
        checks++;
        if (int'(revealedCount) !== expCount) begin failures++; $display("FAIL nonzero_count: got %0d want %0d", revealedCount, expCount); end
        checks++;
        if (write_errors() !== 0) begin failures++; $display("FAIL nonzero_writes: got %0d bad cells want 0", write_errors()); end
        do_ack();
        checks++;
        if (fInit !== 1'b1) begin failures++; $display("FAIL nonzero_ack: got init=%b want 1", fInit); end
    endtask

    task automatic test_full_flood();
        clear_board();
        mineMem[7 * W + 7] = 1'b1;
        compute_adj();
        load_rev();
        model_click(0, 0);
        run_click(0, 0);
        checks++;
        if (int'(revealedCount) !== expCount) begin failures++; $display("FAIL flood_count: got %0d want %0d", revealedCount, expCount); end
        checks++;
        if (writeCnt[7 * W + 7] !== 0) begin failures++; $display("FAIL flood_mine_written: got %0d want 0", writeCnt[7 * W + 7]); end
        checks++;
        if (write_errors() !== 0) begin failures++; $display("FAIL flood_writes: got %0d bad cells want 0", write_errors()); end
        checks++;
        if (lat !== expLat) begin failures++; $display("FAIL flood_latency: got %0d want %0d", lat, expLat); end
        checks++;
        if (hitMine !== 1'b0) begin failures++; $display("FAIL flood_hit: got %b want 0", hitMine); end
        do_ack();
    endtask

    task automatic test_empty_and_repeat();
        clear_board();
        compute_adj();
        load_rev();
        model_click(0, 0);
        run_click(0, 0);
        checks++;
        if (int'(revealedCount) !== expCount) begin failures++; $display("FAIL empty_count: got %0d want %0d", revealedCount, expCount); end
        checks++;
        if (oobCnt !== 0) begin failures++; $display("FAIL empty_oob: got %0d want 0", oobCnt); end
        checks++;
        if (write_errors() !== 0) begin failures++; $display("FAIL empty_writes: got %0d bad cells want 0", write_errors()); end
        checks++;
        if (lat !== expLat) begin failures++; $display("FAIL empty_latency: got %0d want %0d", lat, expLat); end
        do_ack();
        checks++;
        if (fInit !== 1'b1) begin failures++; $display("FAIL empty_ack: got init=%b want 1", fInit); end
        // Same click again on the already-revealed board
        for (int i = 0; i < N; i++) preRev[i] = revMem[i];
        load_rev();
        model_click(0, 0);
        run_click(0, 0);
        checks++;
        if (lat !== expLat) begin failures++; $display("FAIL repeat_latency: got %0d want %0d", lat, expLat); end
        checks++;
        if (revealedCount !== 7'd0) begin failures++; $display("FAIL repeat_count: got %0d want 0", revealedCount); end
        checks++;
        if (write_errors() !== 0) begin failures++; $display("FAIL repeat_writes: got %0d bad cells want 0", write_errors()); end
        @(negedge clk_tb);
        start = 1'b1;
        @(negedge clk_tb);
        start = 1'b0;
        @(negedge clk_tb);
        checks++;
        if (fDone !== 1'b1 || revealedCount !== 7'd0) begin
            failures++; $display("FAIL done_ignores_start: got done=%b count=%0d want 1 0", fDone, revealedCount);
        end
        do_ack();
    endtask

    task automatic test_reset_mid_flood();
        int waitCnt;
        clear_board();
        compute_adj();
        load_rev();
        @(negedge clk_tb);
        clickX = 3'd2; clickY = 3'd5; start = 1'b1;
        @(negedge clk_tb);
        start = 1'b0;
        waitCnt = 0;
        while (!(fNeigh && revealedCount > 7'd3) && waitCnt < 200) begin
            @(negedge clk_tb);
            waitCnt++;
        end
        checks++;
        if (fNeigh !== 1'b1) begin failures++; $display("FAIL midflood_reach_neigh: got neigh=%b want 1", fNeigh); end
        #2 reset_tb = 1'b0;
        #1;
        checks++;
        if ({fInit, fCheck, fPop, fNeigh, fDone} !== 5'b10000) begin
            failures++; $display("FAIL midflood_flags: got %b want 10000", {fInit, fCheck, fPop, fNeigh, fDone});
        end
        checks++;
        if (revealEn !== 1'b0 || revealedCount !== 7'd0 || hitMine !== 1'b0) begin
            failures++; $display("FAIL midflood_outs: got en=%b count=%0d hit=%b want 0 0 0", revealEn, revealedCount, hitMine);
        end
        @(negedge clk_tb);
        reset_tb = 1'b1;
        clear_board();
        mineMem[0] = 1'b1;
        compute_adj();
        load_rev();
        model_click(1, 1);
        run_click(1, 1);
        checks++;
        if (lat !== expLat || int'(revealedCount) !== expCount) begin
            failures++; $display("FAIL midflood_restart: got lat=%0d count=%0d want %0d %0d", lat, revealedCount, expLat, expCount);
        end
        checks++;
        if (write_errors() !== 0) begin failures++; $display("FAIL midflood_restart_writes: got %0d bad cells want 0", write_errors()); end
        do_ack();
    endtask

    task automatic test_random_boards();
        for (int t = 0; t < 12; t++) begin
            int cx, cy;
            clear_board();
            for (int i = 0; i < N; i++) begin
                mineMem[i] = ($urandom_range(0, 99) < 12);
                preRev[i]  = ($urandom_range(0, 99) < 5);
            end
            compute_adj();
            load_rev();
            cx = $urandom_range(0, W - 1);
            cy = $urandom_range(0, H - 1);
            model_click(cx, cy);
            run_click(cx, cy);
            checks++;
            if (lat !== expLat) begin failures++; $display("FAIL rand%0d_latency: got %0d want %0d", t, lat, expLat); end
            checks++;
            if (int'(revealedCount) !== expCount) begin failures++; $display("FAIL rand%0d_count: got %0d want %0d", t, revealedCount, expCount); end
            checks++;
            if (hitMine !== 1'(expHit)) begin failures++; $display("FAIL rand%0d_hit: got %b want %0d", t, hitMine, expHit); end
            checks++;
            if (write_errors() !== 0 || oobCnt !== 0) begin
                failures++; $display("FAIL rand%0d_writes: got %0d bad cells oob=%0d want 0 0", t, write_errors(), oobCnt);
            end
            do_ack();
        end
    endtask

    initial begin
        test_reset();
        test_mine_click();
        test_nonzero_click();
        test_full_flood();
        test_empty_and_repeat();
        test_reset_mid_flood();
        test_random_boards();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
